// File: rtl/int_ctrl_vectored.sv
// int_ctrl_vectored
//   Vectored interrupt controller for up to eight request channels.
//   Requests are latched (edge channels) or followed (level channels),
//   masked, resolved by fixed priority (channel 0 highest) and presented
//   to the CPU as an active-low interrupt. During the acknowledge cycle
//   (M1 and IORQ low) a mode-2 vector is supplied. Nested in-service
//   state is tracked and the highest-priority in-service bit is retired
//   on RETI.
//
// Ports
//   clk, n_reset     : clock, asynchronous active-low reset
//   irq_req          : peripheral requests, active high
//   mask_we/mask_din : mask register load (1 = channel enabled)
//   mem_n_m1         : CPU M1 strobe, active low
//   io_n_iorq        : CPU IORQ strobe, active low
//   cpu_reti         : one-cycle RETI completion pulse
//   int_n_int        : registered interrupt request to CPU, active low
//   vector_dout      : acknowledge vector
//   vector_en        : vector_dout valid
//   irq_in_service   : in-service bits
module int_ctrl_vectored #(
  parameter int unsigned           N_CHANNELS  = 4,
  parameter logic [7:0]            VECTOR_BASE = 8'h00,
  parameter logic [N_CHANNELS-1:0] EDGE_MASK   = '1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [N_CHANNELS-1:0] irq_req,
  input  logic                  mask_we,
  input  logic [N_CHANNELS-1:0] mask_din,
  input  logic                  mem_n_m1,
  input  logic                  io_n_iorq,
  input  logic                  cpu_reti,
  output logic                  int_n_int,
  output logic [7:0]            vector_dout,
  output logic                  vector_en,
  output logic [N_CHANNELS-1:0] irq_in_service
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t                  state;
  logic [N_CHANNELS-1:0]   req_q;
  logic [N_CHANNELS-1:0]   pend_edge;
  logic [N_CHANNELS-1:0]   mask_q;
  logic [2:0]              ch_q;

  logic [N_CHANNELS-1:0]   pending_eff;
  logic [N_CHANNELS-1:0]   eligible;
  logic                    win_valid;
  logic [2:0]              win_idx;
  logic                    isr_valid;
  logic [2:0]              isr_idx;
  logic [N_CHANNELS-1:0]   isr_low_oh;
  logic [N_CHANNELS-1:0]   ch_oh;
  logic                    req_cond;
  logic                    ack_strobe;
  logic                    ack_done;
  logic [N_CHANNELS-1:0]   isr_next;
  logic [N_CHANNELS-1:0]   pend_next;

  always_comb begin
    // Level channels use the registered sample so both modes share latency.
    pending_eff = (pend_edge & EDGE_MASK) | (req_q & ~EDGE_MASK);
    eligible    = pending_eff & mask_q;

    win_valid  = 1'b0;
    win_idx    = '0;
    isr_valid  = 1'b0;
    isr_idx    = '0;
    isr_low_oh = '0;
    ch_oh      = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (eligible[i] && !win_valid) begin
        win_valid = 1'b1;
        win_idx   = i[2:0];
      end
      if (irq_in_service[i] && !isr_valid) begin
        isr_valid     = 1'b1;
        isr_idx       = i[2:0];
        isr_low_oh[i] = 1'b1;
      end
      if (ch_q == i[2:0]) ch_oh[i] = 1'b1;
    end

    req_cond   = win_valid && (!isr_valid || (win_idx < isr_idx));
    ack_strobe = !mem_n_m1 && !io_n_iorq;
    ack_done   = (state == S_ACK) && (mem_n_m1 || io_n_iorq);

    // RETI clears against the old in-service value before the new bit is set.
    isr_next = (cpu_reti ? (irq_in_service & ~isr_low_oh) : irq_in_service)
             | (ack_done ? ch_oh : '0);
    // New edge wins over acknowledge clear of the same channel.
    pend_next = ((pend_edge & ~(ack_done ? ch_oh : '0)) | (irq_req & ~req_q))
              & EDGE_MASK;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      req_q          <= '0;
      pend_edge      <= '0;
      mask_q         <= '0;
      irq_in_service <= '0;
    end else begin
      req_q          <= irq_req;
      pend_edge      <= pend_next;
      irq_in_service <= isr_next;
      if (mask_we) mask_q <= mask_din;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      ch_q        <= '0;
      int_n_int   <= 1'b1;
      vector_en   <= 1'b0;
      vector_dout <= VECTOR_BASE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_cond) begin
            state     <= S_REQ;
            int_n_int <= 1'b0;
          end
        end
        S_REQ: begin
          if (!req_cond) begin
            state     <= S_IDLE;
            int_n_int <= 1'b1;
          end else if (ack_strobe) begin
            state       <= S_ACK;
            ch_q        <= win_idx;
            vector_en   <= 1'b1;
            vector_dout <= VECTOR_BASE | {4'b0000, win_idx, 1'b0};
          end
        end
        S_ACK: begin
          if (ack_done) begin
            state     <= S_IDLE;
            vector_en <= 1'b0;
            int_n_int <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          vector_en <= 1'b0;
          int_n_int <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl_vectored.sv
module tb_int_ctrl_vectored;

  logic       clk;
  logic       n_reset;
  logic [3:0] irq_req;
  logic       mask_we;
  logic [3:0] mask_din;
  logic       mem_n_m1;
  logic       io_n_iorq;
  logic       cpu_reti;
  logic       int_n_int;
  logic [7:0] vector_dout;
  logic       vector_en;
  logic [3:0] irq_in_service;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];
  logic        prev_en = 1'b0;

  int_ctrl_vectored #(
    .N_CHANNELS (4),
    .VECTOR_BASE(8'h40),
    .EDGE_MASK  (4'b1110)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .irq_req       (irq_req),
    .mask_we       (mask_we),
    .mask_din      (mask_din),
    .mem_n_m1      (mem_n_m1),
    .io_n_iorq     (io_n_iorq),
    .cpu_reti      (cpu_reti),
    .int_n_int     (int_n_int),
    .vector_dout   (vector_dout),
    .vector_en     (vector_en),
    .irq_in_service(irq_in_service)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every new vector presentation is matched against the scoreboard.
  always @(negedge clk) begin
    if (vector_en && !prev_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vector_unexpected: got %h expected none at %0t", vector_dout, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (vector_dout !== e) begin
          errors++;
          $display("FAIL vector: got %h expected %h at %0t", vector_dout, e, $time);
        end
      end
    end
    prev_en <= vector_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we  = 1'b1;
    mask_din = m;
    tick();
    mask_we  = 1'b0;
  endtask

  task automatic reti();
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] r);
    irq_req = r;
    tick();
    irq_req = '0;
  endtask

  task automatic ack(input logic [7:0] vec);
    exp_q.push_back(vec);
    mem_n_m1  = 1'b0;
    io_n_iorq = 1'b0;
    tick();
    chk("ack_en", {7'd0, vector_en}, 8'd1);
    chk("ack_int", {7'd0, int_n_int}, 8'd0);
    tick();
    tick();
    mem_n_m1  = 1'b1;
    io_n_iorq = 1'b1;
    tick();
    chk("ack_end_en", {7'd0, vector_en}, 8'd0);
    chk("ack_end_int", {7'd0, int_n_int}, 8'd1);
  endtask

  initial begin
    n_reset   = 1'b0;
    irq_req   = '0;
    mask_we   = 1'b0;
    mask_din  = '0;
    mem_n_m1  = 1'b1;
    io_n_iorq = 1'b1;
    cpu_reti  = 1'b0;
    tick();
    tick();
    chk("rst_int", {7'd0, int_n_int}, 8'd1);
    chk("rst_en", {7'd0, vector_en}, 8'd0);
    chk("rst_vec", vector_dout, 8'h40);
    chk("rst_isr", {4'd0, irq_in_service}, 8'h00);
    n_reset = 1'b1;
    tick();

    // Basic vector on channel 2
    write_mask(4'hF);
    pulse(4'b0100);
    chk("basic_lat1", {7'd0, int_n_int}, 8'd1);
    tick();
    chk("basic_lat2", {7'd0, int_n_int}, 8'd0);
    ack(8'h44);
    chk("basic_isr", {4'd0, irq_in_service}, 8'h04);
    reti();
    chk("basic_reti", {4'd0, irq_in_service}, 8'h00);

    // Priority: 3 and 1 together
    pulse(4'b1010);
    tick();
    chk("prio_req", {7'd0, int_n_int}, 8'd0);
    ack(8'h42);
    chk("prio_isr", {4'd0, irq_in_service}, 8'h02);
    tick();
    tick();
    chk("prio_blocked", {7'd0, int_n_int}, 8'd1);
    reti();
    chk("prio_reti_isr", {4'd0, irq_in_service}, 8'h00);
    chk("prio_reti_int", {7'd0, int_n_int}, 8'd1);
    tick();
    chk("prio_ch3_req", {7'd0, int_n_int}, 8'd0);
    ack(8'h46);
    reti();

    // Nesting: ch2 in service, ch0 (level) preempts
    pulse(4'b0100);
    tick();
    ack(8'h44);
    irq_req = 4'b0001;
    tick();
    tick();
    chk("nest_req", {7'd0, int_n_int}, 8'd0);
    irq_req = '0;
    ack(8'h40);
    chk("nest_isr", {4'd0, irq_in_service}, 8'h05);
    reti();
    chk("nest_reti1", {4'd0, irq_in_service}, 8'h04);
    reti();
    chk("nest_reti2", {4'd0, irq_in_service}, 8'h00);
    tick();
    chk("nest_idle", {7'd0, int_n_int}, 8'd1);

    // Masking and withdrawal
    write_mask(4'h0);
    pulse(4'b0010);
    tick();
    tick();
    chk("mask_none", {7'd0, int_n_int}, 8'd1);
    write_mask(4'h2);
    chk("mask_next", {7'd0, int_n_int}, 8'd1);
    tick();
    chk("mask_req", {7'd0, int_n_int}, 8'd0);
    write_mask(4'h0);
    chk("mask_hold", {7'd0, int_n_int}, 8'd0);
    tick();
    chk("mask_withdraw", {7'd0, int_n_int}, 8'd1);

    // Level channel 0 held through ACK and RETI
    write_mask(4'h1);
    irq_req = 4'b0001;
    tick();
    tick();
    chk("lvl_req", {7'd0, int_n_int}, 8'd0);
    ack(8'h40);
    tick();
    chk("lvl_blocked", {7'd0, int_n_int}, 8'd1);
    reti();
    tick();
    chk("lvl_rereq", {7'd0, int_n_int}, 8'd0);
    irq_req = '0;
    ack(8'h40);
    reti();
    chk("lvl_isr", {4'd0, irq_in_service}, 8'h00);

    // Spurious acknowledge in IDLE
    mem_n_m1  = 1'b0;
    io_n_iorq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("spur_en", {7'd0, vector_en}, 8'd0);
      chk("spur_int", {7'd0, int_n_int}, 8'd1);
    end
    mem_n_m1  = 1'b1;
    io_n_iorq = 1'b1;
    tick();

    // Reset in the middle of a nested ACK
    write_mask(4'b0101);
    pulse(4'b0100);
    tick();
    ack(8'h44);
    irq_req = 4'b0001;
    tick();
    tick();
    chk("rack_req", {7'd0, int_n_int}, 8'd0);
    exp_q.push_back(8'h40);
    mem_n_m1  = 1'b0;
    io_n_iorq = 1'b0;
    tick();
    chk("rack_en", {7'd0, vector_en}, 8'd1);
    chk("rack_isr_pre", {4'd0, irq_in_service}, 8'h04);
    @(negedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    chk("rack_en_rst", {7'd0, vector_en}, 8'd0);
    chk("rack_int_rst", {7'd0, int_n_int}, 8'd1);
    chk("rack_isr_rst", {4'd0, irq_in_service}, 8'h00);
    chk("rack_vec_rst", vector_dout, 8'h40);
    tick();
    n_reset   = 1'b1;
    mem_n_m1  = 1'b1;
    io_n_iorq = 1'b1;
    tick();
    tick();
    chk("post_rst_masked", {7'd0, int_n_int}, 8'd1);
    irq_req = '0;
    tick();

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
